// File: rtl/fpu_scheduler.sv
// Two-requester round-robin front end for a fixed-latency FPU: it accepts one
// operation, launches it, waits out the pipeline and returns the result to its owner.
module fpu_scheduler #(
  parameter int bitness      = 32,
  parameter int command_size = 2,
  parameter int latency      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*bitness-1:0]      req_first,
  input  logic [2*bitness-1:0]      req_second,
  input  logic [2*command_size-1:0] req_command,
  output logic [1:0]                resp_valid,
  input  logic [1:0]                resp_ready,
  output logic [bitness-1:0]        resp_result,
  output logic [bitness-1:0]        fpu_first,
  output logic [bitness-1:0]        fpu_second,
  output logic [command_size-1:0]   fpu_command,
  output logic                      fpu_start,
  input  logic [bitness-1:0]        fpu_result,
  output logic                      busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  localparam logic [7:0] LatencyInit = 8'(latency);

  logic [1:0]              state_q, state_d;
  logic [7:0]              counter_q, counter_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic [bitness-1:0]      first_q, first_d;
  logic [bitness-1:0]      second_q, second_d;
  logic [command_size-1:0] command_q, command_d;
  logic [bitness-1:0]      result_q, result_d;

  logic grant_idx;
  logic accept;
  logic resp_handshake;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_idx = 1'b0;
    case (req_valid)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant_q;
      default: grant_idx = 1'b0;
    endcase
  end

  // Ready is gated by reset as well so it reads 0 while reset is held.
  assign req_ready      = (state_q == IDLE && reset && req_valid != 2'b00) ?
                          {grant_idx, ~grant_idx} : 2'b00;
  assign accept         = |(req_valid & req_ready);
  assign resp_handshake = (state_q == RESPOND) && resp_ready[owner_q];

  // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    second_d     = second_q;
    command_d    = command_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          owner_d   = grant_idx;
          first_d   = req_first[int'(grant_idx)*bitness +: bitness];
          second_d  = req_second[int'(grant_idx)*bitness +: bitness];
          command_d = req_command[int'(grant_idx)*command_size +: command_size];
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        counter_d = LatencyInit;
      end
      WAIT: begin
        counter_d = counter_q - 8'd1;
        if (counter_q == 8'd1) begin
          result_d = fpu_result;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        if (resp_handshake) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      counter_q    <= 8'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      first_q      <= '0;
      second_q     <= '0;
      command_q    <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      second_q     <= second_d;
      command_q    <= command_d;
      result_q     <= result_d;
    end
  end

  assign fpu_first   = first_q;
  assign fpu_second  = second_q;
  assign fpu_command = command_q;
  assign fpu_start   = (state_q == ISSUE);
  assign resp_valid  = (state_q == RESPOND) ? {owner_q, ~owner_q} : 2'b00;
  assign resp_result = result_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_scheduler.sv
// Bench for fpu_scheduler: directed scenarios plus randomized traffic compared
// against a transaction-level model of arbitration, timing and results.
module tb_fpu_scheduler;
  localparam int W   = 32;
  localparam int C   = 2;
  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [2*W-1:0] req_first, req_second;
  logic [2*C-1:0] req_command;
  logic [W-1:0]   resp_result, fpu_first, fpu_second, fpu_result;
  logic [C-1:0]   fpu_command;
  logic           fpu_start, busy;
  logic           stub_fixed;

  // Shared stimulus for the latency-sweep instances.
  logic [1:0]     s_valid, s_resp_ready;
  logic [2*W-1:0] s_first, s_second;
  logic [2*C-1:0] s_command;
  logic [1:0]     l1_ready, l1_rv, l255_ready, l255_rv;
  logic [W-1:0]   l1_res, l1_a, l1_b, l1_fr, l255_res, l255_a, l255_b, l255_fr;
  logic [C-1:0]   l1_c, l255_c;
  logic           l1_start, l1_busy, l255_start, l255_busy;

  int checks = 0;
  int errors = 0;

  // Requester-side model state.
  bit           pend [2];
  logic [W-1:0] op_a [2];
  logic [W-1:0] op_b [2];
  logic [C-1:0] op_c [2];
  int           last_grant_m;

  function automatic logic [W-1:0] fpu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [C-1:0] c);
    case (c)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  always_comb fpu_result = stub_fixed ? 32'h40400000 : fpu_model(fpu_first, fpu_second, fpu_command);
  assign l1_fr   = fpu_model(l1_a, l1_b, l1_c);
  assign l255_fr = fpu_model(l255_a, l255_b, l255_c);

  fpu_scheduler #(.bitness(W), .command_size(C), .latency(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_first(req_first), .req_second(req_second), .req_command(req_command),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .fpu_first(fpu_first), .fpu_second(fpu_second), .fpu_command(fpu_command),
    .fpu_start(fpu_start), .fpu_result(fpu_result), .busy(busy));

  fpu_scheduler #(.bitness(W), .command_size(C), .latency(1)) u_l1 (
    .clock(clock), .reset(reset), .req_valid(s_valid), .req_ready(l1_ready),
    .req_first(s_first), .req_second(s_second), .req_command(s_command),
    .resp_valid(l1_rv), .resp_ready(s_resp_ready), .resp_result(l1_res),
    .fpu_first(l1_a), .fpu_second(l1_b), .fpu_command(l1_c),
    .fpu_start(l1_start), .fpu_result(l1_fr), .busy(l1_busy));

  fpu_scheduler #(.bitness(W), .command_size(C), .latency(255)) u_l255 (
    .clock(clock), .reset(reset), .req_valid(s_valid), .req_ready(l255_ready),
    .req_first(s_first), .req_second(s_second), .req_command(s_command),
    .resp_valid(l255_rv), .resp_ready(s_resp_ready), .resp_result(l255_res),
    .fpu_first(l255_a), .fpu_second(l255_b), .fpu_command(l255_c),
    .fpu_start(l255_start), .fpu_result(l255_fr), .busy(l255_busy));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    op_a[i] = $urandom;
    op_b[i] = $urandom;
    op_c[i] = C'($urandom_range(0, 3));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]             = pend[i];
      req_first[i*W +: W]      = op_a[i];
      req_second[i*W +: W]     = op_b[i];
      req_command[i*C +: C]    = op_c[i];
    end
  endtask

  // One complete transaction, entered and left at a negedge with the DUT idle.
  // regen: 0 = no new requests, 1 = winner re-requests at once, 2 = random arrivals.
  task automatic run_op(input int bp, input bit early, input int regen, output int g);
    logic [1:0]   exp_rdy;
    logic [W-1:0] ea, eb, er;
    logic [C-1:0] ec;
    if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
    drive_reqs();
    #1;
    if (pend[0] && pend[1]) g = 1 - last_grant_m;
    else                    g = pend[1] ? 1 : 0;
    exp_rdy = (g == 1) ? 2'b10 : 2'b01;
    check("req_ready_grant", req_ready, exp_rdy);
    ea = op_a[g]; eb = op_b[g]; ec = op_c[g];
    er = stub_fixed ? 32'h40400000 : fpu_model(ea, eb, ec);
    @(posedge clock);
    @(negedge clock);
    pend[g] = 1'b0;
    if (regen == 1) new_req(g);
    if (regen == 2) for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
    drive_reqs();
    check("fpu_start_issue", fpu_start, 1);
    check("busy_issue", busy, 1);
    check("req_ready_issue", req_ready, 0);
    check("fpu_first_latched", fpu_first, ea);
    check("fpu_second_latched", fpu_second, eb);
    check("fpu_command_latched", fpu_command, ec);
    resp_ready = 2'b00;
    resp_ready[1-g] = 1'($urandom_range(0, 1));
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clock);
      check("no_resp_in_wait", resp_valid, 0);
      check("no_start_in_wait", fpu_start, 0);
      check("fpu_first_stable", fpu_first, ea);
      if (j == LAT && early) resp_ready[g] = 1'b1;
    end
    @(negedge clock);
    check("resp_valid_rise", resp_valid, exp_rdy);
    check("resp_result", resp_result, er);
    if (!early) begin
      for (int j = 0; j < bp; j++) begin
        @(negedge clock);
        check("resp_valid_hold", resp_valid, exp_rdy);
        check("resp_result_hold", resp_result, er);
        check("busy_respond", busy, 1);
        check("req_ready_respond", req_ready, 0);
      end
      resp_ready[g] = 1'b1;
    end
    @(negedge clock);
    check("resp_valid_clear", resp_valid, 0);
    check("busy_idle", busy, 0);
    resp_ready   = 2'b00;
    last_grant_m = g;
  endtask

  initial begin
    int g, off1, off255;
    logic [W-1:0] r1, r255;
    bit stable;
    stub_fixed   = 1'b0;
    resp_ready   = 2'b00;
    s_valid      = 2'b00;
    s_resp_ready = 2'b11;
    s_first = '0; s_second = '0; s_command = '0;
    last_grant_m = 1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    new_req(0); new_req(1);
    drive_reqs();

    // Reset state with both requesters already asserting valid.
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_fpu_first", fpu_first, 0);
    check("rst_fpu_second", fpu_second, 0);
    check("rst_fpu_command", fpu_command, 0);
    check("rst_fpu_start", fpu_start, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // Tie right after reset, then continuous contention: 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      run_op(i % 3, (i % 2) == 1, 1, g);
      check("grant_order", 64'(g), 64'(i % 2));
    end

    // Fixed-result stub, single requester 0.
    stub_fixed = 1'b1;
    pend[1] = 1'b0;
    pend[0] = 1'b1; op_a[0] = 32'h3F800000; op_b[0] = 32'h40000000; op_c[0] = 2'd0;
    run_op(0, 1'b1, 0, g);
    check("single_req_owner", 64'(g), 64'd0);
    stub_fixed = 1'b0;

    // Long response backpressure.
    run_op(10, 1'b0, 2, g);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) run_op(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 2, g);

    // Reset pulse in the middle of WAIT.
    pend[0] = 1'b0; pend[1] = 1'b0;
    new_req(0);
    drive_reqs();
    @(posedge clock);
    @(negedge clock);
    pend[0] = 1'b0;
    drive_reqs();
    repeat (2) @(negedge clock);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_result", resp_result, 0);
    check("midrst_fpu_first", fpu_first, 0);
    check("midrst_fpu_second", fpu_second, 0);
    check("midrst_fpu_command", fpu_command, 0);
    check("midrst_fpu_start", fpu_start, 0);
    check("midrst_req_ready", req_ready, 0);
    @(negedge clock);
    reset = 1'b1;
    last_grant_m = 1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      check("post_rst_no_resp", resp_valid, 0);
      check("post_rst_idle", busy, 0);
    end
    new_req(0); new_req(1);
    run_op(0, 1'b1, 0, g);
    check("post_rst_tie_owner", 64'(g), 64'd0);

    // Latency sweep on the 1- and 255-cycle instances.
    s_first   = {32'h0, 32'h12345678};
    s_second  = {32'h0, 32'h01010101};
    s_command = {2'd0, 2'd0};
    s_valid   = 2'b01;
    #1;
    check("sweep_l1_ready", l1_ready, 2'b01);
    check("sweep_l255_ready", l255_ready, 2'b01);
    @(posedge clock);
    @(negedge clock);
    s_valid = 2'b00;
    off1 = -1; off255 = -1; stable = 1'b1;
    r1 = '0; r255 = '0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clock);
      if (off1 < 0 && l1_rv != 2'b00) begin off1 = j; r1 = l1_res; end
      if (off255 < 0 && l255_rv != 2'b00) begin off255 = j; r255 = l255_res; end
      if (l255_a !== 32'h12345678 || l255_b !== 32'h01010101) stable = 1'b0;
    end
    check("sweep_l1_offset", 64'(off1), 64'd2);
    check("sweep_l255_offset", 64'(off255), 64'd256);
    check("sweep_l1_result", r1, 32'h13355779);
    check("sweep_l255_result", r255, 32'h13355779);
    check("sweep_operands_stable", 64'(stable), 64'd1);
    check("sweep_l255_idle", l255_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
